// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
//   WIDTH_DEF / DEPTH_DEF : default word width and entry count
//   word_t                : a default-width data word
//   addr_w()              : address width for a given entry count
package regfile_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;

    typedef logic [WIDTH_DEF-1:0] word_t;

    // Address width for a power-of-two entry count.
    // Depths of 0 or 1 still get a 1-bit address so that port widths stay legal.
    function automatic int addr_w(input int depth);
        if (depth <= 1) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage : regfile_pkg

// File: rtl/regfile_entry.sv
// One register-file entry: a WIDTH-bit register with load enable.
//   clk : clock, loads on rising edge when en=1
//   clr : asynchronous active-high clear, forces q to 0 immediately
//   en  : load enable
//   d   : data to load
//   q   : stored value
module regfile_entry #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule : regfile_entry

// File: rtl/regfile_2r1w_param.sv
// Parametrised register file: DEPTH words of WIDTH bits, one write port,
// two independent read ports with registered outputs (one-cycle latency).
//   clk               : clock, all state changes on the rising edge
//   clr               : asynchronous active-high clear of entries and outputs
//   we/waddr/wdata    : write port
//   re_a/raddr_a      : port A read enable / address
//   rdata_a           : port A registered read data (holds while re_a=0)
//   re_b/raddr_b      : port B read enable / address
//   rdata_b           : port B registered read data (holds while re_b=0)
// ZERO_REG=1 makes entry 0 a constant zero; BYPASS=1 forwards same-edge
// write data to a read of the same address.
module regfile_2r1w_param
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = WIDTH_DEF,
    parameter  int DEPTH    = DEPTH_DEF,
    parameter  bit ZERO_REG = 1'b1,
    parameter  bit BYPASS   = 1'b1,
    localparam int ADDR_W   = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);

    localparam int NPORTS = 2;

    // Current contents of every entry, as seen before this edge's write.
    logic [WIDTH-1:0] entry_q [DEPTH];

    // Port inputs gathered into arrays so both ports share one generate body.
    logic              re    [NPORTS];
    logic [ADDR_W-1:0] raddr [NPORTS];

    assign re[0]    = re_a;
    assign re[1]    = re_b;
    assign raddr[0] = raddr_a;
    assign raddr[1] = raddr_b;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (ZERO_REG && gi == 0) begin : g_zero
                // No storage at all: writes to address 0 simply have nowhere to go.
                assign entry_q[gi] = '0;
            end else begin : g_reg
                logic wen;

                assign wen = we && (waddr == ADDR_W'(gi));

                regfile_entry #(
                    .WIDTH (WIDTH)
                ) u_entry (
                    .clk (clk),
                    .clr (clr),
                    .en  (wen),
                    .d   (wdata),
                    .q   (entry_q[gi])
                );
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports: mux, optional bypass, output register
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            logic [WIDTH-1:0] rd_next;
            logic [WIDTH-1:0] rd_reg;

            always_comb begin
                rd_next = entry_q[raddr[gi]];
                if (BYPASS && we && (waddr == raddr[gi])) begin
                    rd_next = wdata;
                end
                // The zero entry wins over bypass so a discarded write to
                // address 0 is never forwarded.
                if (ZERO_REG && (raddr[gi] == '0)) begin
                    rd_next = '0;
                end
            end

            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    rd_reg <= '0;
                end else if (re[gi]) begin
                    rd_reg <= rd_next;
                end
            end
        end
    endgenerate

    assign rdata_a = g_port[0].rd_reg;
    assign rdata_b = g_port[1].rd_reg;

endmodule : regfile_2r1w_param
